// File: rtl/tmma_dispatch.sv
// tmma issue-channel receiver: queues issued instructions, then per instruction
// pulses MAC start, streams per-row operand reads, counts responses and returns a token.
`ifndef TINST_TYPE_WIDTH
`define TINST_TYPE_WIDTH 4
`endif
`ifndef TLOAD_DATAW_WIDTH
`define TLOAD_DATAW_WIDTH 2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif

module tmma_dispatch #(
    parameter int DEPTH      = 2,
    parameter int ROWS       = 16,
    parameter int ROW_STRIDE = 64,
    parameter int ROW_W      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_tmma_valid_i,
    output logic                             issue_tmma_ready_o,
    input  logic [`TINST_TYPE_WIDTH-1:0]     issue_tmma_type_i,
    input  logic [`TLOAD_DATAW_WIDTH-1:0]    issue_tmma_data_width_i,
    input  logic [`ADDR_WIDTH-1:0]           issue_tmma_addr0_i,
    input  logic [`ADDR_WIDTH-1:0]           issue_tmma_addr1_i,
    input  logic [`TMMA_PRECISION_WIDTH-1:0] issue_tmma_precision_i,
    input  logic                             issue_tmma_acc_i,
    output logic                             mac_start_o,
    output logic [`TMMA_PRECISION_WIDTH-1:0] mac_precision_o,
    output logic [`TLOAD_DATAW_WIDTH-1:0]    mac_data_width_o,
    output logic                             mac_acc_o,
    output logic                             rd_req_valid_o,
    input  logic                             rd_req_ready_i,
    output logic [`ADDR_WIDTH-1:0]           rd_req_addr0_o,
    output logic [`ADDR_WIDTH-1:0]           rd_req_addr1_o,
    output logic [ROW_W-1:0]                 rd_req_row_o,
    output logic                             rd_req_last_o,
    input  logic                             rd_resp_valid_i,
    output logic                             done_valid_o,
    input  logic                             done_ready_i,
    output logic [`TINST_TYPE_WIDTH-1:0]     done_type_o,
    output logic                             busy_o
);
    // state | meaning
    // IDLE  | waiting for a queued instruction; pops the FIFO head when one exists
    // START | one-cycle MAC start pulse; row and response counters cleared
    // ISSUE | streaming row read requests
    // WAIT  | all rows requested, collecting outstanding responses
    // DONE  | completion token offered until accepted
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int TW      = `TINST_TYPE_WIDTH;
    localparam int DW      = `TLOAD_DATAW_WIDTH;
    localparam int AW      = `ADDR_WIDTH;
    localparam int PW      = `TMMA_PRECISION_WIDTH;
    localparam int ENTRY_W = TW + DW + 2 * AW + PW + 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int RCW     = ROW_W + 1;

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [RCW-1:0]   RESP_FULL = RCW'(ROWS);
    localparam logic [AW-1:0]    STRIDE    = AW'(ROW_STRIDE);

    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W-1:0]   fifo_cnt_nxt;
    logic               issue_ready_q;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    logic [2:0]         state;
    logic [ROW_W-1:0]   row;
    logic [RCW-1:0]     resp_cnt;
    logic [RCW-1:0]     resp_cnt_nxt;
    logic               resp_hit;
    logic               req_last;
    logic [AW-1:0]      row_off;

    logic [TW-1:0]      type_q;
    logic [DW-1:0]      dw_q;
    logic [AW-1:0]      base0_q;
    logic [AW-1:0]      base1_q;
    logic [PW-1:0]      prec_q;
    logic               acc_q;

    assign fifo_empty = (fifo_cnt == '0);
    assign push       = issue_tmma_valid_i & issue_ready_q;
    assign pop        = (state == S_IDLE) & ~fifo_empty;
    assign push_entry = {issue_tmma_type_i, issue_tmma_data_width_i, issue_tmma_addr0_i,
                         issue_tmma_addr1_i, issue_tmma_precision_i, issue_tmma_acc_i};
    assign head_entry = fifo_mem[rd_ptr];

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_nxt = fifo_cnt + 1'b1;
        end else if (pop && !push) begin
            fifo_cnt_nxt = fifo_cnt - 1'b1;
        end
    end

    // Ready is a registered !full, so a pop never frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            issue_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt      <= fifo_cnt_nxt;
            issue_ready_q <= (fifo_cnt_nxt != CNT_W'(DEPTH));
        end
    end

    assign req_last     = (row == ROW_LAST);
    assign resp_hit     = rd_resp_valid_i & ((state == S_ISSUE) | (state == S_WAIT))
                          & (resp_cnt != RESP_FULL);
    assign resp_cnt_nxt = resp_cnt + RCW'(resp_hit);
    assign row_off      = AW'(row) * STRIDE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            row      <= '0;
            resp_cnt <= '0;
            type_q   <= '0;
            dw_q     <= '0;
            base0_q  <= '0;
            base1_q  <= '0;
            prec_q   <= '0;
            acc_q    <= '0;
        end else begin
            if (resp_hit) begin
                resp_cnt <= resp_cnt_nxt;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {type_q, dw_q, base0_q, base1_q, prec_q, acc_q} <= head_entry;
                        state <= S_START;
                    end
                end
                S_START: begin
                    row      <= '0;
                    resp_cnt <= '0;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (rd_req_ready_i) begin
                        row <= row + 1'b1;
                        if (req_last) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (resp_cnt_nxt == RESP_FULL) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (done_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign issue_tmma_ready_o = issue_ready_q;
    assign mac_start_o        = (state == S_START);
    assign mac_precision_o    = prec_q;
    assign mac_data_width_o   = dw_q;
    assign mac_acc_o          = acc_q;
    assign rd_req_valid_o     = (state == S_ISSUE);
    assign rd_req_addr0_o     = base0_q + row_off;
    assign rd_req_addr1_o     = base1_q + row_off;
    assign rd_req_row_o       = row;
    assign rd_req_last_o      = (state == S_ISSUE) & req_last;
    assign done_valid_o       = (state == S_DONE);
    assign done_type_o        = type_q;
    assign busy_o             = (state != S_IDLE) | ~fifo_empty;

endmodule
